// File: rtl/ethernet_transmitter.sv
// Byte-wide Ethernet MAC transmit path: preamble/SFD, payload, zero pad, FCS, IFG.
// Ports:
//   clk, rst_n            byte clock, asynchronous active-low reset
//   s_data/s_valid/s_last payload stream in (dest MAC first), s_ready back-pressure out
//   txd/tx_en/tx_er       registered PHY transmit interface
//   busy                  high whenever the transmitter is not idle
//   frame_sent            1-cycle pulse after a good frame, tx_length valid with it
//   frame_error           1-cycle pulse on underrun or oversize abort
//   tx_length             data+pad+FCS byte count of the last good frame
module ethernet_transmitter #(
  parameter bit          ENABLE_CRC    = 1'b1,
  parameter bit          ENABLE_PAD    = 1'b1,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned IFG_BYTES     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        busy,
  output logic        frame_sent,
  output logic        frame_error,
  output logic [15:0] tx_length
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [15:0] PAD_LEN  = 16'(MIN_FRAME_LEN - 4);
  localparam logic [15:0] MAX_DATA = ENABLE_CRC ? 16'(MAX_FRAME_LEN - 4) : 16'(MAX_FRAME_LEN);
  localparam logic [15:0] FCS_LEN  = ENABLE_CRC ? 16'd4 : 16'd0;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(6);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [31:0] POLY     = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;       // preamble, FCS byte and IFG cycle counter
  logic [15:0]      n;         // data+pad bytes of the current frame
  logic [31:0]      crc;
  logic             frame_ok;  // current frame reached its end without abort
  logic [15:0]      n_inc;

  // Reflected CRC-32 update, one byte LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  // Saturating byte count.
  assign n_inc = (n == 16'hFFFF) ? n : n + 16'd1;

  // Transmit sequencer with registered PHY and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n           <= '0;
      crc         <= 32'hFFFFFFFF;
      frame_ok    <= 1'b0;
      s_ready     <= 1'b0;
      txd         <= 8'h00;
      tx_en       <= 1'b0;
      tx_er       <= 1'b0;
      busy        <= 1'b0;
      frame_sent  <= 1'b0;
      frame_error <= 1'b0;
      tx_length   <= '0;
    end else begin
      frame_sent  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          txd     <= 8'h00;
          tx_en   <= 1'b0;
          tx_er   <= 1'b0;
          s_ready <= 1'b0;
          // Frame start only peeks at s_valid; the first byte waits for DATA.
          if (s_valid) begin
            state    <= S_PREAMBLE;
            txd      <= 8'h55;
            tx_en    <= 1'b1;
            cnt      <= '0;
            n        <= '0;
            crc      <= 32'hFFFFFFFF;
            frame_ok <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          if (cnt == PRE_LAST) begin
            // SFD on the wire while the first payload byte is already accepted.
            txd     <= 8'hD5;
            s_ready <= 1'b1;
            state   <= S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (n == MAX_DATA || !s_valid) begin
            // Oversize or underrun: one tx_er cycle, then discard the rest of the input.
            txd         <= 8'h00;
            tx_er       <= 1'b1;
            frame_error <= 1'b1;
            if (s_valid && s_last) begin
              s_ready <= 1'b0;
              cnt     <= '0;
              state   <= S_IFG;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            txd <= s_data;
            crc <= crc_byte(crc, s_data);
            n   <= n_inc;
            if (s_last) begin
              s_ready <= 1'b0;
              cnt     <= '0;
              if (ENABLE_PAD && n_inc < PAD_LEN) begin
                state <= S_PAD;
              end else if (ENABLE_CRC) begin
                state <= S_FCS;
              end else begin
                frame_ok <= 1'b1;
                state    <= S_IFG;
              end
            end
          end
        end

        S_PAD: begin
          txd <= 8'h00;
          crc <= crc_byte(crc, 8'h00);
          n   <= n_inc;
          if (n_inc >= PAD_LEN) begin
            cnt <= '0;
            if (ENABLE_CRC) begin
              state <= S_FCS;
            end else begin
              frame_ok <= 1'b1;
              state    <= S_IFG;
            end
          end
        end

        S_FCS: begin
          // FCS is the complemented remainder, low byte first.
          txd <= 8'(~crc >> {cnt[1:0], 3'b000});
          if (cnt == FCS_LAST) begin
            cnt      <= '0;
            frame_ok <= 1'b1;
            state    <= S_IFG;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          tx_er <= 1'b0;
          if (s_valid && s_last) begin
            s_ready <= 1'b0;
            cnt     <= '0;
            state   <= S_IFG;
          end
        end

        S_IFG: begin
          txd     <= 8'h00;
          tx_en   <= 1'b0;
          tx_er   <= 1'b0;
          s_ready <= 1'b0;
          if (cnt == '0 && frame_ok) begin
            frame_sent <= 1'b1;
            tx_length  <= n + FCS_LEN;
            frame_ok   <= 1'b0;
          end
          if (cnt == IFG_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_transmitter.sv
// Self-checking bench for ethernet_transmitter: drives payload frames on the stream
// input, records every tx_en burst on the PHY side and compares against frames built
// from the Ethernet framing rules (preamble, SFD, pad, CRC-32 FCS).
`timescale 1ns/1ps
module tb_ethernet_transmitter;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  txd;
  logic        tx_en;
  logic        tx_er;
  logic        busy;
  logic        frame_sent;
  logic        frame_error;
  logic [15:0] tx_length;

  ethernet_transmitter dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .busy(busy),
    .frame_sent(frame_sent), .frame_error(frame_error), .tx_length(tx_length)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Wire capture
  bq_t         wbytes;
  int          fr_start[$];
  int          fr_len[$];
  bit          fr_er[$];
  int          fr_first[$];
  int          fr_last[$];
  logic [15:0] len_q[$];
  int          sent_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;

  bq_t         pay;
  bq_t         exp_q;
  logic [31:0] crc_tbl [256];

  always @(posedge clk) cyc <= cyc + 1;

  // PHY-side monitor, sampled on the falling edge.
  initial begin : monitor
    bit in_fr;
    int c_start, c_first, c_last;
    bit c_er;
    in_fr = 0; c_start = 0; c_first = 0; c_last = 0; c_er = 0;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        if (!in_fr) begin
          in_fr = 1; c_start = wbytes.size(); c_er = 0; c_first = cyc;
        end
        if (tx_er === 1'b1) c_er = 1;
        else wbytes.push_back(txd);
        c_last = cyc;
      end else if (in_fr) begin
        in_fr = 0;
        fr_start.push_back(c_start);
        fr_len.push_back(wbytes.size() - c_start);
        fr_er.push_back(c_er);
        fr_first.push_back(c_first);
        fr_last.push_back(c_last);
      end
      if (frame_sent === 1'b1) begin
        sent_cnt++;
        len_q.push_back(tx_length);
      end
      if (frame_error === 1'b1) err_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain CRC-32 register over a byte range (no final complement).
  function automatic logic [31:0] crc_of(input bq_t b, input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
    return c;
  endfunction

  // Expected wire image: preamble+SFD, then either a truncated payload or the full frame.
  task automatic build_exp(input bq_t p, input int trunc);
    bq_t body;
    logic [31:0] fcs;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    if (trunc >= 0) begin
      for (int i = 0; i < trunc; i++) exp_q.push_back(p[i]);
    end else begin
      body = p;
      while (body.size() < 60) body.push_back(8'h00);
      fcs = ~crc_of(body, 0, body.size());
      foreach (body[i]) exp_q.push_back(body[i]);
      for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    end
  endtask

  task automatic cmp_frame(input string tag, input int r);
    int bad;
    bad = 0;
    check({tag, "_len"}, 32'(fr_len[r]), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < fr_len[r]; i++)
      if (wbytes[fr_start[r] + i] !== exp_q[i]) bad++;
    check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic check_good(input string tag, input bq_t p, input int r);
    build_exp(p, -1);
    cmp_frame(tag, r);
    check({tag, "_tx_er"}, 32'(fr_er[r]), 32'd0);
    check({tag, "_residue"}, crc_of(wbytes, fr_start[r] + 8, fr_start[r] + fr_len[r]),
          32'hDEBB20E3);
  endtask

  task automatic gen(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drive pay[] with valid/ready; drop valid once at drop_at, stop early at stop_at.
  task automatic send(input int drop_at, input int stop_at);
    int i, guard, target;
    bit dropped;
    i = 0; guard = 0; dropped = 0;
    target = (stop_at >= 0) ? stop_at : pay.size();
    while (i < target && guard < 5000) begin
      if (i == drop_at && !dropped) begin
        s_valid = 1'b0;
        dropped = 1;
      end else begin
        s_valid = 1'b1;
        s_data  = pay[i];
        s_last  = (i == pay.size() - 1);
        if (s_ready === 1'b1) i++;
      end
      @(negedge clk);
      guard++;
    end
    check("send_complete", 32'(i), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy !== 1'b0 || tx_en !== 1'b0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, {30'd0, busy, tx_en}, 32'd0);
  endtask

  initial begin : stim
    bq_t p1, p2;
    int  s0, e0, r;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_txd", 32'(txd), 32'h0);
    check("rst_tx_en", 32'(tx_en), 32'h0);
    check("rst_tx_er", 32'(tx_er), 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_sent", 32'(frame_sent), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_tx_length", 32'(tx_length), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 60-byte counting payload, no padding needed
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    s0 = sent_cnt; e0 = err_cnt;
    send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t1_idle");
    check_good("t1", pay, fr_len.size() - 1);
    check("t1_sent", 32'(sent_cnt - s0), 32'd1);
    check("t1_tx_length", 32'(tx_length), 32'd64);

    // Short payload gets zero padding
    gen(14);
    s0 = sent_cnt;
    send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t2_idle");
    check_good("t2", pay, fr_len.size() - 1);
    check("t2_sent", 32'(sent_cnt - s0), 32'd1);
    check("t2_tx_length", 32'(tx_length), 32'd64);

    // Random lengths straddling the pad boundary
    for (int f = 0; f < 3; f++) begin
      int len;
      len = $urandom_range(1, 150);
      gen(len);
      send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
      wait_idle("rnd_idle");
      check_good("rnd", pay, fr_len.size() - 1);
      check("rnd_tx_length", 32'(tx_length), 32'((len < 60 ? 60 : len) + 4));
    end
    check("rnd_no_errors", 32'(err_cnt - e0), 32'd0);

    // Underrun at payload byte 20
    gen(40);
    s0 = sent_cnt; e0 = err_cnt;
    send(20, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t3_idle");
    r = fr_len.size() - 1;
    build_exp(pay, 20);
    cmp_frame("t3", r);
    check("t3_tx_er", 32'(fr_er[r]), 32'd1);
    check("t3_frame_error", 32'(err_cnt - e0), 32'd1);
    check("t3_no_sent", 32'(sent_cnt - s0), 32'd0);

    // Oversize: aborts after the maximum data byte count
    gen(1600);
    s0 = sent_cnt; e0 = err_cnt;
    send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t4_idle");
    build_exp(pay, 1514);
    cmp_frame("t4", fr_len.size() - 1);
    check("t4_tx_er", 32'(fr_er[fr_len.size() - 1]), 32'd1);
    check("t4_frame_error", 32'(err_cnt - e0), 32'd1);
    check("t4_no_sent", 32'(sent_cnt - s0), 32'd0);
    check("t3_t4_gap_ge_ifg",
          32'((fr_first[fr_len.size() - 1] - fr_last[fr_len.size() - 2] - 1) >= 12), 32'd1);

    // Back-to-back frames with s_valid held high
    s0 = sent_cnt;
    gen(100); p1 = pay;
    send(-1, -1);
    gen(100); p2 = pay;
    send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t5_idle");
    r = fr_len.size() - 1;
    check_good("t5a", p1, r - 1);
    check_good("t5b", p2, r);
    check("t5_gap", 32'(fr_first[r] - fr_last[r - 1] - 1), 32'd12);
    check("t5_sent", 32'(sent_cnt - s0), 32'd2);
    check("t5_len_a", 32'(len_q[len_q.size() - 2]), 32'd104);
    check("t5_len_b", 32'(len_q[len_q.size() - 1]), 32'd104);

    // Asynchronous reset in the middle of the payload
    gen(200);
    send(-1, 30);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tx_en", 32'(tx_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gen(60);
    s0 = sent_cnt;
    send(-1, -1); s_valid = 1'b0; s_last = 1'b0;
    wait_idle("t6_idle");
    check_good("t6", pay, fr_len.size() - 1);
    check("t6_sent", 32'(sent_cnt - s0), 32'd1);
    check("t6_tx_length", 32'(tx_length), 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
